// File: rtl/bullet_pkg.sv
// Shared definitions for the bullet pool.
//   SCREEN_W / SCREEN_H : visible playfield size in pixels (640 x 480)
//   dir_t               : 3-bit launch direction, 0=N, 1=NE ... 7=NW, clockwise
//   dir_sign_t          : per-axis unit sign (-1, 0, +1) of a direction
//   dir_sign()          : the direction-to-(dx,dy) sign table; y grows southward
//   idx_width()         : width of a slot index, at least 1 bit
package bullet_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [2:0] {
    DIR_N  = 3'd0,
    DIR_NE = 3'd1,
    DIR_E  = 3'd2,
    DIR_SE = 3'd3,
    DIR_S  = 3'd4,
    DIR_SW = 3'd5,
    DIR_W  = 3'd6,
    DIR_NW = 3'd7
  } dir_t;

  typedef struct packed {
    logic signed [1:0] sx;
    logic signed [1:0] sy;
  } dir_sign_t;

  localparam logic signed [1:0] S_NEG  = 2'sb11;
  localparam logic signed [1:0] S_ZERO = 2'sb00;
  localparam logic signed [1:0] S_POS  = 2'sb01;

  // North moves toward smaller y because scanlines count downward.
  function automatic dir_sign_t dir_sign(input dir_t d);
    dir_sign_t s;
    case (d)
      DIR_N:   s = '{sx: S_ZERO, sy: S_NEG};
      DIR_NE:  s = '{sx: S_POS,  sy: S_NEG};
      DIR_E:   s = '{sx: S_POS,  sy: S_ZERO};
      DIR_SE:  s = '{sx: S_POS,  sy: S_POS};
      DIR_S:   s = '{sx: S_ZERO, sy: S_POS};
      DIR_SW:  s = '{sx: S_NEG,  sy: S_POS};
      DIR_W:   s = '{sx: S_NEG,  sy: S_ZERO};
      DIR_NW:  s = '{sx: S_NEG,  sy: S_NEG};
      default: s = '{sx: S_ZERO, sy: S_ZERO};
    endcase
    return s;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bullet_pool_if.sv
// Fire / kill handshake bundle between the game logic and the bullet pool.
//   fire_req   : level request to launch a bullet
//   ship_x/y   : launch position
//   fire_dir   : launch direction
//   fire_ack   : one-cycle pulse, the cycle after a fire was accepted
//   kill_valid : collision kill request for slot kill_idx
// master = game logic side, slave = bullet pool side.
interface bullet_pool_if
  import bullet_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int IDX_W   = 2
) ();

  logic               fire_req;
  logic [COORD_W-1:0] ship_x;
  logic [COORD_W-1:0] ship_y;
  dir_t               fire_dir;
  logic               fire_ack;
  logic               kill_valid;
  logic [IDX_W-1:0]   kill_idx;

  modport master (
    output fire_req, ship_x, ship_y, fire_dir, kill_valid, kill_idx,
    input  fire_ack
  );

  modport slave (
    input  fire_req, ship_x, ship_y, fire_dir, kill_valid, kill_idx,
    output fire_ack
  );

endinterface

// File: rtl/bullet_slot.sv
// One bullet slot: position, direction, age, movement and pixel compare.
//   clk, reset        : clock, synchronous active-high reset
//   frame_tick        : advance the bullet one frame
//   load              : capture load_x/load_y/load_dir, start a new bullet
//   kill              : collision kill (ignored if the slot is not live)
//   px, py            : current scan pixel
//   active            : slot is live (registered)
//   hit               : combinational, live bullet covers (px,py)
// Build option BULLET_WRAP_EN: defined -> bullets leaving the playfield wrap
// to the opposite edge; undefined -> they are retired on that tick.
module bullet_slot
  import bullet_pkg::*;
#(
  parameter int COORD_W   = 10,
  parameter int SPEED     = 2,
  parameter int HALF_SIZE = 1,
  parameter int LIFETIME  = 90
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               load,
  input  logic               kill,
  input  logic [COORD_W-1:0] load_x,
  input  logic [COORD_W-1:0] load_y,
  input  dir_t               load_dir,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  output logic               active,
  output logic               hit
);

  localparam int AGE_W = $clog2(LIFETIME + 1);
  localparam logic [AGE_W-1:0]       AGE_LAST = AGE_W'(LIFETIME - 1);
  localparam logic signed [COORD_W:0] STEP    = (COORD_W + 1)'(SPEED);
  localparam logic signed [COORD_W:0] HALF    = (COORD_W + 1)'(HALF_SIZE);
  localparam logic signed [COORD_W:0] X_SPAN  = (COORD_W + 1)'(SCREEN_W);
  localparam logic signed [COORD_W:0] Y_SPAN  = (COORD_W + 1)'(SCREEN_H);

  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  dir_t               dir;
  logic [AGE_W-1:0]   age;

  dir_sign_t               sgn;
  logic signed [COORD_W:0] nx;
  logic signed [COORD_W:0] ny;
  logic [COORD_W-1:0]      x_next;
  logic [COORD_W-1:0]      y_next;
  logic                    leave;
  logic signed [COORD_W:0] hx;
  logic signed [COORD_W:0] hy;

  function automatic logic signed [COORD_W:0] step_of(input logic signed [1:0] s);
    if (s > 2'sb00)      return STEP;
    else if (s < 2'sb00) return -STEP;
    else                 return '0;
  endfunction

  // One step can overshoot an edge by at most SPEED, so a single fold suffices.
  function automatic logic [COORD_W-1:0] wrap(input logic signed [COORD_W:0] v,
                                               input logic signed [COORD_W:0] span);
    logic signed [COORD_W:0] t;
    if (v[COORD_W])    t = v + span;
    else if (v >= span) t = v - span;
    else               t = v;
    return t[COORD_W-1:0];
  endfunction

  function automatic logic in_range(input logic signed [COORD_W:0] v,
                                    input logic signed [COORD_W:0] span);
    return !v[COORD_W] && (v < span);
  endfunction

  assign sgn = dir_sign(dir);
  assign nx  = $signed({1'b0, x}) + step_of(sgn.sx);
  assign ny  = $signed({1'b0, y}) + step_of(sgn.sy);

`ifdef BULLET_WRAP_EN
  assign leave  = 1'b0;
  assign x_next = wrap(nx, X_SPAN);
  assign y_next = wrap(ny, Y_SPAN);
`else
  assign leave  = !in_range(nx, X_SPAN) || !in_range(ny, Y_SPAN);
  assign x_next = nx[COORD_W-1:0];
  assign y_next = ny[COORD_W-1:0];
`endif

  // Stored coordinates are kept after retirement; gating on active keeps
  // stale positions off the screen.
  assign hx  = $signed({1'b0, px}) - $signed({1'b0, x});
  assign hy  = $signed({1'b0, py}) - $signed({1'b0, y});
  assign hit = active && (hx <= HALF) && (hx >= -HALF)
                      && (hy <= HALF) && (hy >= -HALF);

  // Priority: kill, then load, then frame advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      active <= 1'b0;
      x      <= '0;
      y      <= '0;
      dir    <= DIR_N;
      age    <= '0;
    end else if (kill && active) begin
      active <= 1'b0;
    end else if (load) begin
      active <= 1'b1;
      x      <= load_x;
      y      <= load_y;
      dir    <= load_dir;
      age    <= '0;
    end else if (frame_tick && active) begin
      if ((age == AGE_LAST) || leave) begin
        active <= 1'b0;
      end else begin
        x   <= x_next;
        y   <= y_next;
        age <= age + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bullet_pool.sv
// Pool of N_BULLETS independent bullets for a 640x480 sprite engine.
//   clk, reset  : clock, synchronous active-high reset
//   frame_tick  : one-cycle pulse per video frame
//   fire_bus    : fire/kill handshake (bullet_pool_if.slave)
//   px, py      : scan pixel being rendered
//   pix_on      : registered, a live bullet covers the previous (px,py)
//   pix_idx     : registered, lowest slot covering it (0 when none)
//   active      : per-slot live mask
//   full        : every slot is live
// Build option BULLET_WRAP_EN selects wrap-around vs retire at the screen
// edge (see bullet_slot).
module bullet_pool
  import bullet_pkg::*;
#(
  parameter int N_BULLETS = 4,
  parameter int COORD_W   = 10,
  parameter int SPEED     = 2,
  parameter int HALF_SIZE = 1,
  parameter int LIFETIME  = 90,
  parameter int COOLDOWN  = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            frame_tick,
  bullet_pool_if.slave                    fire_bus,
  input  logic [COORD_W-1:0]              px,
  input  logic [COORD_W-1:0]              py,
  output logic                            pix_on,
  output logic [idx_width(N_BULLETS)-1:0] pix_idx,
  output logic [N_BULLETS-1:0]            active,
  output logic                            full
);

  localparam int IDX_W = idx_width(N_BULLETS);
  localparam int CD_W  = $clog2(COOLDOWN + 2);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);

  logic [CD_W-1:0]      cooldown;
  logic                 accept;
  logic [IDX_W-1:0]     free_idx;
  logic [N_BULLETS-1:0] load_vec;
  logic [N_BULLETS-1:0] kill_vec;
  logic [N_BULLETS-1:0] hit_vec_p0;
  logic [IDX_W-1:0]     hit_idx_p0;
  logic                 hit_any_p0;

  // Allocation looks only at registered slot state, so a slot retired this
  // cycle becomes available on the next one.
  assign full   = &active;
  assign accept = fire_bus.fire_req && !full && (cooldown == '0);

  always_comb begin
    free_idx = '0;
    for (int i = N_BULLETS - 1; i >= 0; i--) begin
      if (!active[i]) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    hit_idx_p0 = '0;
    for (int i = N_BULLETS - 1; i >= 0; i--) begin
      if (hit_vec_p0[i]) hit_idx_p0 = IDX_W'(i);
    end
  end

  assign hit_any_p0 = |hit_vec_p0;

  for (genvar g = 0; g < N_BULLETS; g++) begin : g_slot
    assign load_vec[g] = accept && (free_idx == IDX_W'(g));
    assign kill_vec[g] = fire_bus.kill_valid && (fire_bus.kill_idx == IDX_W'(g));

    bullet_slot #(
      .COORD_W   (COORD_W),
      .SPEED     (SPEED),
      .HALF_SIZE (HALF_SIZE),
      .LIFETIME  (LIFETIME)
    ) u_slot (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .load       (load_vec[g]),
      .kill       (kill_vec[g]),
      .load_x     (fire_bus.ship_x),
      .load_y     (fire_bus.ship_y),
      .load_dir   (fire_bus.fire_dir),
      .px         (px),
      .py         (py),
      .active     (active[g]),
      .hit        (hit_vec_p0[g])
    );
  end

  // p0 -> registered outputs: ack, cooldown, pixel hit
  always_ff @(posedge clk) begin
    if (reset) begin
      fire_bus.fire_ack <= 1'b0;
      cooldown          <= '0;
      pix_on            <= 1'b0;
      pix_idx           <= '0;
    end else begin
      fire_bus.fire_ack <= accept;
      if (accept) begin
        cooldown <= CD_LOAD;
      end else if (frame_tick && (cooldown != '0)) begin
        cooldown <= cooldown - 1'b1;
      end
      pix_on  <= hit_any_p0;
      pix_idx <= hit_any_p0 ? hit_idx_p0 : '0;
    end
  end

endmodule
